// File: rtl/truth_table_capture.sv
// Truth-table capture engine: sweeps all minterms of a 7-input combinational
// function, assembles its truth table and on-set count, and hands both off over valid/ready.
module truth_table_capture #(
    parameter int N_INPUTS      = 7,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [N_INPUTS-1:0]      x_out,
    input  logic                     f_in,
    output logic                     busy,
    output logic                     tt_valid,
    input  logic                     tt_ready,
    output logic [(2**N_INPUTS)-1:0] tt_data,
    output logic [7:0]               ones_count
);

    // state | meaning
    // IDLE  | waiting for start; last result still on tt_data/ones_count
    // DRIVE | stepping x_out through minterms 0..127, sampling f_in
    // DONE  | result presented with tt_valid, waiting for tt_ready

    localparam int TT_W = 2**N_INPUTS;
    localparam logic [3:0] SETTLE_TC = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [N_INPUTS-1:0] pattern, pattern_d;
    logic [3:0]          settle_cnt, settle_d;
    logic [TT_W-1:0]     acc, acc_d;
    logic [7:0]          run_cnt, run_cnt_d;
    logic [TT_W-1:0]     tt_d;
    logic [7:0]          ones_d;
    logic                settle_last;
    logic                pattern_last;

    assign settle_last  = (settle_cnt == SETTLE_TC);
    assign pattern_last = (pattern == {N_INPUTS{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pattern    <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            run_cnt    <= '0;
            tt_data    <= '0;
            ones_count <= '0;
        end else begin
            state      <= state_d;
            pattern    <= pattern_d;
            settle_cnt <= settle_d;
            acc        <= acc_d;
            run_cnt    <= run_cnt_d;
            tt_data    <= tt_d;
            ones_count <= ones_d;
        end
    end

    always_comb begin
        state_d   = state;
        pattern_d = pattern;
        settle_d  = settle_cnt;
        acc_d     = acc;
        run_cnt_d = run_cnt;
        tt_d      = tt_data;
        ones_d    = ones_count;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = DRIVE;
                    pattern_d = '0;
                    settle_d  = '0;
                    acc_d     = '0;
                    run_cnt_d = '0;
                end
            end
            DRIVE: begin
                if (settle_last) begin
                    settle_d       = '0;
                    acc_d[pattern] = f_in;
                    run_cnt_d      = run_cnt + 8'(f_in);
                    if (pattern_last) begin
                        // final bit is folded in on the same edge that publishes the table
                        state_d   = DONE;
                        pattern_d = '0;
                        tt_d      = acc_d;
                        ones_d    = run_cnt_d;
                    end else begin
                        pattern_d = pattern + 1'b1;
                    end
                end else begin
                    settle_d = settle_cnt + 4'd1;
                end
            end
            DONE: begin
                if (tt_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign x_out    = pattern;
    assign busy     = (state == DRIVE);
    assign tt_valid = (state == DONE);

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: two instances (settle 1 and 3) driven by a
// selectable combinational function; table-driven scans plus reset/backpressure cases.
module tb_truth_table_capture;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start_v[2];
    logic         ready_v[2];
    logic         f_v[2];
    logic         busy_v[2];
    logic         valid_v[2];
    logic [6:0]   x_v[2];
    logic [127:0] tt_v[2];
    logic [7:0]   cnt_v[2];

    int           fsel;
    logic [127:0] lut;

    int nvec = 0;
    int nerr = 0;

    function automatic logic dut_fn(int sel, logic [6:0] x, logic [127:0] l);
        case (sel)
            0:       return 1'b0;
            1:       return x[0];
            2:       return x[6];
            3:       return &x;
            4:       return x[0] ^ x[1];
            5:       return l[x];
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        f_v[0] = dut_fn(fsel, x_v[0], lut);
        f_v[1] = dut_fn(fsel, x_v[1], lut);
    end

    truth_table_capture #(.N_INPUTS(7), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .x_out(x_v[0]), .f_in(f_v[0]),
        .busy(busy_v[0]), .tt_valid(valid_v[0]), .tt_ready(ready_v[0]),
        .tt_data(tt_v[0]), .ones_count(cnt_v[0])
    );

    truth_table_capture #(.N_INPUTS(7), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .x_out(x_v[1]), .f_in(f_v[1]),
        .busy(busy_v[1]), .tt_valid(valid_v[1]), .tt_ready(ready_v[1]),
        .tt_data(tt_v[1]), .ones_count(cnt_v[1])
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the truth table is just f evaluated at every minterm index.
    function automatic logic [127:0] model_tt(int sel, logic [127:0] l);
        logic [127:0] t;
        t = '0;
        for (int k = 0; k < 128; k++) t[k] = dut_fn(sel, 7'(k), l);
        return t;
    endfunction

    function automatic int popc(logic [127:0] v);
        int n;
        n = 0;
        for (int k = 0; k < 128; k++) n += int'(v[k]);
        return n;
    endfunction

    task automatic check_zero(input int d, input string tag);
        check({tag, "_x"},     128'(x_v[d]),     128'd0);
        check({tag, "_busy"},  128'(busy_v[d]),  128'd0);
        check({tag, "_valid"}, 128'(valid_v[d]), 128'd0);
        check({tag, "_tt"},    tt_v[d],          128'd0);
        check({tag, "_cnt"},   128'(cnt_v[d]),   128'd0);
    endtask

    task automatic run_scan(input int d, input int settle, input logic [127:0] exp_tt,
                            input int exp_cnt, input int bp, input string tag);
        logic [127:0] prev_tt;
        logic [7:0]   prev_cnt;
        logic         ok;
        prev_tt  = tt_v[d];
        prev_cnt = cnt_v[d];
        @(negedge clk);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1 start_v[d] = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 128 * settle; k++) begin
            @(negedge clk);
            if (busy_v[d] !== 1'b1 || valid_v[d] !== 1'b0 || x_v[d] !== 7'(k / settle) ||
                tt_v[d] !== prev_tt || cnt_v[d] !== prev_cnt)
                ok = 1'b0;
            // ready and start are both meaningless while scanning
            ready_v[d] = 1'($urandom_range(0, 1));
            start_v[d] = 1'($urandom_range(0, 1));
            @(posedge clk);
        end
        #1;
        ready_v[d] = 1'b0;
        start_v[d] = 1'b0;
        check({tag, "_trace"}, 128'(ok), 128'd1);
        @(negedge clk);
        check({tag, "_valid"}, 128'(valid_v[d]), 128'd1);
        check({tag, "_busy"},  128'(busy_v[d]),  128'd0);
        check({tag, "_x0"},    128'(x_v[d]),     128'd0);
        check({tag, "_tt"},    tt_v[d],          exp_tt);
        check({tag, "_cnt"},   128'(cnt_v[d]),   128'(exp_cnt));

        ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            start_v[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (valid_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || tt_v[d] !== exp_tt ||
                cnt_v[d] !== 8'(exp_cnt) || x_v[d] !== 7'd0)
                ok = 1'b0;
        end
        if (bp > 0) check({tag, "_hold"}, 128'(ok), 128'd1);

        // start asserted on the handshake edge must not launch a scan
        ready_v[d] = 1'b1;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        ready_v[d] = 1'b0;
        start_v[d] = 1'b0;
        @(negedge clk);
        check({tag, "_idle_valid"}, 128'(valid_v[d]), 128'd0);
        check({tag, "_idle_busy"},  128'(busy_v[d]),  128'd0);
        check({tag, "_keep_tt"},    tt_v[d],          exp_tt);
        check({tag, "_keep_cnt"},   128'(cnt_v[d]),   128'(exp_cnt));
    endtask

    typedef struct {
        int           d;
        int           settle;
        int           fsel;
        logic [127:0] l;
        logic [127:0] exp_tt;
        int           exp_cnt;
        int           bp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        int   waited;
        rst_n = 1'b0;
        fsel  = 0;
        lut   = '0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            ready_v[i] = 1'b0;
        end

        vecs.push_back('{0, 1, 0, 128'd0, 128'd0, 0, 0});
        vecs.push_back('{0, 1, 1, 128'd0, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 64, 0});
        vecs.push_back('{0, 1, 2, 128'd0, 128'hFFFFFFFFFFFFFFFF0000000000000000, 64, 0});
        vecs.push_back('{0, 1, 3, 128'd0, 128'h80000000000000000000000000000000, 1, 50});
        vecs.push_back('{1, 3, 4, 128'd0, 128'h66666666666666666666666666666666, 64, 0});
        vecs.push_back('{0, 1, 6, 128'd0, {128{1'b1}}, 128, 3});
        for (int r = 0; r < 5; r++) begin
            v.d      = (r == 4) ? 1 : 0;
            v.settle = (r == 4) ? 3 : 1;
            v.fsel   = 5;
            v.l      = {$urandom, $urandom, $urandom, $urandom};
            v.exp_tt = model_tt(5, v.l);
            v.exp_cnt = popc(v.exp_tt);
            v.bp     = int'($urandom_range(0, 4));
            vecs.push_back(v);
        end

        #23;
        check_zero(0, "rst1");
        check_zero(1, "rst3");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            fsel = vecs[i].fsel;
            lut  = vecs[i].l;
            run_scan(vecs[i].d, vecs[i].settle, vecs[i].exp_tt, vecs[i].exp_cnt,
                     vecs[i].bp, $sformatf("vec%0d", i));
        end

        // Reset mid-scan, then a clean rescan must carry no stale bits.
        fsel = 2;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1 start_v[0] = 1'b0;
        waited = 0;
        while (x_v[0] !== 7'd60 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("midrst_reach60", 128'(x_v[0]), 128'd60);
        rst_n = 1'b0;
        #1;
        check_zero(0, "midrst");
        @(negedge clk);
        rst_n = 1'b1;
        fsel = 1;
        run_scan(0, 1, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 64, 0, "rescan");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/truth_table_capture.md
Name: truth_table_capture

Overview:
- Sequential stimulus/capture engine that sits upstream and downstream of a 7-input single-output combinational function under test (DUT). Drives the DUT inputs x0..x6 and samples its output out.
- On each start, sweeps all 128 input minterms in ascending order and assembles the 128-bit truth table. Also counts the on-set size.
- Presents the result over a valid/ready handshake to the classification logic that consumes it.

Parameters:
- N_INPUTS, 7, number of DUT inputs; fixed at 7, table width is 2**N_INPUTS = 128.
- SETTLE_CYCLES, 1, cycles each minterm is held on x_out before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan; accepted only in IDLE.
- x_out  output  7  DUT stimulus. x_out[i] drives DUT input xi; the minterm index k has x0 = bit 0.
- f_in  input  1  DUT output out; combinational function of x_out.
- busy  output  1  high while scanning (DRIVE state).
- tt_valid  output  1  result available.
- tt_ready  input  1  consumer accepts result.
- tt_data  output  128  truth table; bit k = f(minterm k). Hex MSB-first rendering is the table string.
- ones_count  output  8  number of 1 bits in tt_data, 0..128.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; x_out=0, busy=0, tt_valid=0, tt_data=0, ones_count=0; internal pattern, settle counter, accumulator and running count all 0. Reset mid-scan discards the partial table. No output shows partial data afterwards.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - start=1 at edge E0 moves to DRIVE.
  - pattern=0, x_out=0, settle counter=0, busy=1, accumulator and running count cleared.
- DRIVE:
  - Each minterm is held for exactly SETTLE_CYCLES cycles.
  - At the last of those edges, f_in is written into accumulator bit [pattern], and the running count increments if f_in=1.
  - If pattern<127, pattern increments and x_out follows at the same edge.
  - If pattern=127, go to DONE.
- DRIVE→DONE transition (same edge):
  - tt_data loads the final accumulator, including the bit sampled at that edge.
  - ones_count loads the final count; tt_valid=1, busy=0.
  - x_out returns to 0.
- Latency: tt_valid rises after edge E0 + 128*SETTLE_CYCLES. With SETTLE_CYCLES=1 that is 128 cycles after start acceptance.
- DONE:
  - tt_valid, tt_data and ones_count are held stable until tt_valid&&tt_ready at an edge.
  - At that edge go to IDLE with tt_valid=0. tt_data and ones_count keep their last values.
- tt_ready while not valid has no effect.
- start is ignored in DRIVE and DONE, including the handshake edge itself. A new scan needs start in IDLE.
- Count arithmetic is 8-bit unsigned; the maximum of 128 cannot overflow.
- tt_data and ones_count change only at scan completion or reset. No intermediate values are ever visible.
- Sampling timing: f_in must settle within SETTLE_CYCLES-1 cycles plus one combinational path of x_out changes.

Test Plan:
- Constant-0 DUT, SETTLE=1: start pulse → busy for 128 cycles; tt_valid after exactly 128 cycles; tt_data=0; ones_count=0.
- DUT f=x0: → tt_data=0xAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, ones_count=64. DUT f=x6: → 0xFFFFFFFFFFFFFFFF0000000000000000, ones_count=64.
- DUT f=AND of x0..x6: → tt_data=0x80000000000000000000000000000000, ones_count=1. Also check that x_out steps 0,1,…,127 one per cycle, then returns to 0.
- Backpressure: tt_ready held 0 for 50 cycles after tt_valid → outputs stable, start pulses ignored; tt_ready=1 → IDLE next edge; new start accepted.
- SETTLE_CYCLES=3, DUT f=x0 XOR x1: → each x_out value held 3 cycles, tt_valid after 384 cycles, tt_data=0x66666666666666666666666666666666, ones_count=64.
- Reset mid-scan: rst_n low at pattern 60 → all outputs 0 immediately; rescan with f=x0 gives correct 0xAAAA… result and no stale bits.
